// File: rtl/data_mem_responder_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// data_mem_responder_if : valid/ready request + response bus, core <-> data memory
// Revision: 1.0
// -----------------------------------------------------------------------------
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// data_mem_responder : single-outstanding word memory with WAIT_CYCLES wait states
// Revision: 1.0
// -----------------------------------------------------------------------------
module data_mem_responder #(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  wire logic           clk,
   input  wire logic           rst,
   data_mem_responder_if.slave bus
);
   localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_req_ready;
   logic        r_resp_valid;
   logic        r_resp_err;
   logic [31:0] r_resp_rdata;
   logic        r_write;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_mem [DEPTH];

   logic          w_accept;
   logic          w_commit;
   logic          w_cmt_write;
   logic [31:0]   w_cmt_addr;
   logic [31:0]   w_cmt_wdata;
   logic          w_err;
   logic [c_AW-1:0] w_idx;
   logic [31:0]   w_rdata_next;

   // With zero wait states the commit happens on the accept edge itself, so
   // the request is taken straight from the bus instead of the latches.
   always_comb begin
      w_accept    = bus.req_valid & r_req_ready;
      w_cmt_write = (r_state == S_IDLE) ? bus.req_write : r_write;
      w_cmt_addr  = (r_state == S_IDLE) ? bus.req_addr  : r_addr;
      w_cmt_wdata = (r_state == S_IDLE) ? bus.req_wdata : r_wdata;
      w_commit    = ((r_state == S_WAIT) && (r_cnt == 4'd1)) ||
                    ((WAIT_CYCLES == 0) && (r_state == S_IDLE) && w_accept);
      w_err       = (w_cmt_addr[1:0] != 2'b00) ||
                    ({1'b0, w_cmt_addr[31:2]} >= 31'(DEPTH));
      w_idx       = w_cmt_addr[c_AW+1:2];
      w_rdata_next = (!w_err && !w_cmt_write) ? r_mem[w_idx] : 32'd0;
   end

   always_ff @(posedge clk) begin
      if (w_commit && w_cmt_write && !w_err) begin
         r_mem[w_idx] <= w_cmt_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= 4'd0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= 32'd0;
         r_write      <= 1'b0;
         r_addr       <= 32'd0;
         r_wdata      <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_write     <= bus.req_write;
                  r_addr      <= bus.req_addr;
                  r_wdata     <= bus.req_wdata;
                  r_cnt       <= 4'(WAIT_CYCLES);
                  r_req_ready <= 1'b0;
                  if (w_commit) begin
                     r_state      <= S_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= w_err;
                     r_resp_rdata <= w_rdata_next;
                  end else begin
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (w_commit) begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= w_err;
                  r_resp_rdata <= w_rdata_next;
               end
            end
            S_RESP: begin
               if (bus.resp_ready) begin
                  r_state      <= S_IDLE;
                  r_req_ready  <= 1'b1;
                  r_resp_valid <= 1'b0;
                  r_resp_err   <= 1'b0;
                  r_resp_rdata <= 32'd0;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_req_ready  <= 1'b1;
               r_resp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready  = r_req_ready;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_rdata = r_resp_rdata;
   assign bus.resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_data_mem_responder : directed + randomized check against a word-array model
// Revision: 1.0
// -----------------------------------------------------------------------------
module tb_data_mem_responder;
   localparam int c_DEPTH = 256;
   localparam int c_W_A   = 2;
   localparam int c_W_B   = 0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   data_mem_responder_if bus_a ();
   data_mem_responder_if bus_b ();

   data_mem_responder #(.DEPTH(c_DEPTH), .WAIT_CYCLES(c_W_A)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.slave)
   );

   data_mem_responder #(.DEPTH(c_DEPTH), .WAIT_CYCLES(c_W_B)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.slave)
   );

   int errors = 0;
   int checks = 0;
   // key = dut * 65536 + word index
   logic [31:0] model [int];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int d, input logic v, input logic w,
                        input logic [31:0] a, input logic [31:0] wd);
      if (d == 0) begin
         bus_a.req_valid = v; bus_a.req_write = w; bus_a.req_addr = a; bus_a.req_wdata = wd;
      end else begin
         bus_b.req_valid = v; bus_b.req_write = w; bus_b.req_addr = a; bus_b.req_wdata = wd;
      end
   endtask

   task automatic set_rr(input int d, input logic r);
      if (d == 0) bus_a.resp_ready = r;
      else        bus_b.resp_ready = r;
   endtask

   function automatic logic get_ready(input int d);
      return (d == 0) ? bus_a.req_ready : bus_b.req_ready;
   endfunction
   function automatic logic get_valid(input int d);
      return (d == 0) ? bus_a.resp_valid : bus_b.resp_valid;
   endfunction
   function automatic logic [31:0] get_rdata(input int d);
      return (d == 0) ? bus_a.resp_rdata : bus_b.resp_rdata;
   endfunction
   function automatic logic get_err(input int d);
      return (d == 0) ? bus_a.resp_err : bus_b.resp_err;
   endfunction

   function automatic bit addr_bad(input logic [31:0] a);
      longint unsigned ua;
      ua = a;
      return ((ua % 4) != 0) || ((ua / 4) >= c_DEPTH);
   endfunction

   task automatic check_idle(input int d, input string tag);
      check_eq({tag, " req_ready"},  get_ready(d), 1);
      check_eq({tag, " resp_valid"}, get_valid(d), 0);
      check_eq({tag, " resp_rdata"}, get_rdata(d), 0);
      check_eq({tag, " resp_err"},   get_err(d),   0);
   endtask

   // One complete request/response, with `stall` extra cycles of resp_ready low.
   task automatic txn(input int d, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input int stall, input string tag);
      int n;
      int key;
      bit bad;
      bit have_exp;
      logic [31:0] exp_rd;
      int wcyc;
      wcyc = (d == 0) ? c_W_A : c_W_B;
      @(negedge clk);
      drive(d, 1'b1, wr, a, wd);
      set_rr(d, 1'b0);
      n = 0;
      while (!get_ready(d) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         check_eq({tag, " accept timeout"}, 0, 1);
         drive(d, 1'b0, 1'b0, 32'd0, 32'd0);
         return;
      end
      @(posedge clk); #1;
      drive(d, 1'b0, ~wr, $urandom, $urandom);
      n = 1;
      while (!get_valid(d) && n < 50) begin
         check_eq({tag, " busy ready"}, get_ready(d), 0);
         @(posedge clk); #1;
         n++;
      end
      check_eq({tag, " latency"}, n, wcyc + 1);

      bad      = addr_bad(a);
      key      = d * 65536 + int'(a >> 2);
      have_exp = 1'b1;
      exp_rd   = 32'd0;
      if (!bad && !wr) begin
         if (model.exists(key)) exp_rd = model[key];
         else                   have_exp = 1'b0;
      end
      if (!bad && wr) model[key] = wd;

      check_eq({tag, " err"}, get_err(d), bad);
      if (have_exp) check_eq({tag, " rdata"}, get_rdata(d), exp_rd);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check_eq({tag, " stall valid"}, get_valid(d), 1);
         check_eq({tag, " stall ready"}, get_ready(d), 0);
         check_eq({tag, " stall err"},   get_err(d),   bad);
         if (have_exp) check_eq({tag, " stall rdata"}, get_rdata(d), exp_rd);
      end
      set_rr(d, 1'b1);
      @(posedge clk); #1;
      set_rr(d, 1'b0);
      check_eq({tag, " post valid"}, get_valid(d), 0);
      check_eq({tag, " post ready"}, get_ready(d), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int last_acc;
      int cyc;
      bit have_inflight;
      logic [31:0] inflight;
      int acc_cnt;
      int d;
      int sel;
      logic [31:0] a;

      rst = 1'b1;
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
      set_rr(0, 1'b0);
      set_rr(1, 1'b0);
      repeat (2) @(negedge clk);
      check_idle(0, "reset a");
      check_idle(1, "reset b");
      rst = 1'b0;

      // Directed sequence on the two-wait-state instance
      txn(0, 1, 32'h10,  32'hDEADBEEF, 0, "store 0x10");
      txn(0, 0, 32'h10,  32'h0,        0, "load 0x10");
      txn(0, 1, 32'h13,  32'h12345678, 0, "misaligned store");
      txn(0, 0, 32'h10,  32'h0,        0, "reload 0x10");
      txn(0, 0, 32'h400, 32'h0,        0, "load 0x400");
      txn(0, 1, 32'h400, 32'h55555555, 0, "store 0x400");
      txn(0, 0, 32'hFFFFFFFC, 32'h0,   0, "load top");
      txn(0, 1, 32'h3FC, 32'hA5A5F00F, 0, "store 0x3FC");
      txn(0, 0, 32'h3FC, 32'h0,        0, "load 0x3FC");
      txn(0, 0, 32'h0,   32'h0,        0, "load 0x0");
      txn(0, 0, 32'h10,  32'h0,        5, "stalled load");

      // Reset during WAIT discards the pending store
      txn(0, 1, 32'h20, 32'h0, 0, "clear 0x20");
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_idle(0, "mid-wait reset");
      @(negedge clk);
      rst = 1'b0;
      txn(0, 0, 32'h20, 32'h0, 0, "load 0x20 after reset");

      // Zero-wait instance: preload, then back-to-back loads with resp_ready high
      for (int i = 0; i < 4; i++) begin
         txn(1, 1, 32'h40 + 32'(i * 4), $urandom, 0, "b preload");
      end
      set_rr(1, 1'b1);
      last_acc = -1;
      cyc = 0;
      acc_cnt = 0;
      have_inflight = 1'b0;
      inflight = 32'd0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (have_inflight) begin
            check_eq("b2b valid", get_valid(1), 1);
            check_eq("b2b rdata", get_rdata(1), model[65536 + int'(inflight >> 2)]);
            have_inflight = 1'b0;
         end
         if (get_ready(1)) begin
            if (last_acc >= 0) check_eq("b2b interval", cyc - last_acc, 2);
            last_acc = cyc;
            inflight = 32'h40 + 32'((acc_cnt % 4) * 4);
            drive(1, 1'b1, 1'b0, inflight, 32'd0);
            have_inflight = 1'b1;
            acc_cnt++;
         end
         cyc++;
      end
      @(negedge clk);
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
      repeat (3) @(negedge clk);
      set_rr(1, 1'b0);
      check_idle(1, "b2b drained");

      // Randomized traffic on both instances
      for (int i = 0; i < 40; i++) begin
         d   = int'($urandom_range(0, 1));
         sel = int'($urandom_range(0, 9));
         case (sel)
            6:       a = {22'd0, 8'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
            7:       a = 32'h400 + 32'($urandom_range(0, 63) * 4);
            8:       a = {1'b1, 29'($urandom), 2'b00};
            9:       a = 32'h3FC;
            default: a = 32'($urandom_range(0, 15) * 4);
         endcase
         txn(d, bit'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 3)), "random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
